// File: rtl/router_pkg.sv
// Shared router constants and helpers.
// Holds the output FIFO defaults (byte width, depth, idle timeout) and the
// header byte-count width/helper used when a packet header is read out.
package router_pkg;

    // Number of destination ports on the router.
    localparam int unsigned ROUTER_NUM_PORTS = 3;

    // Output FIFO defaults.
    localparam int unsigned FIFO_DATA_W  = 8;
    localparam int unsigned FIFO_DEPTH   = 16;
    localparam int unsigned FIFO_TIMEOUT = 30;

    // Byte counter loaded from a header: payload length field plus parity.
    localparam int unsigned HDR_CNT_W = 6;
    typedef logic [HDR_CNT_W-1:0] byte_cnt_t;

    // Header bits [7:2] carry the payload length; one extra byte of parity.
    function automatic byte_cnt_t hdr_byte_cnt(input logic [HDR_CNT_W-1:0] len_field);
        return len_field + byte_cnt_t'(1);
    endfunction

endpackage

// File: rtl/router_fifo_timer.sv
// Idle watchdog for the router output FIFO.
// Counts cycles in which the FIFO holds data but nobody reads it. When the
// count would pass TIMEOUT-1 the FIFO is flushed on that edge and soft_rst_o
// pulses high for the following cycle.
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   vld_out_i   FIFO non-empty
//   rd_en_i     read request from destination side
//   flush_o     combinational: flush the FIFO on this edge
//   soft_rst_o  registered one-cycle pulse after a timeout flush
module router_fifo_timer #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_out_i,
    input  logic rd_en_i,
    output logic flush_o,
    output logic soft_rst_o
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             soft_rst_q, soft_rst_d;

    always_comb begin
        idle_d     = idle_q;
        flush_o    = 1'b0;
        if (!vld_out_i || rd_en_i) begin
            idle_d = '0;
        end else if (idle_q == IdleLast) begin
            flush_o = 1'b1;
            idle_d  = '0;
        end else begin
            idle_d = idle_q + IdleW'(1);
        end
        soft_rst_d = flush_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_q     <= '0;
            soft_rst_q <= 1'b0;
        end else begin
            idle_q     <= idle_d;
            soft_rst_q <= soft_rst_d;
        end
    end

    assign soft_rst_o = soft_rst_q;

endmodule

// File: rtl/router_out_fifo.sv
// Router output FIFO with packet-aware read data and idle self-flush.
// Each entry stores a byte plus its header flag. Reading a header loads a
// byte counter with the packet's remaining length; once the packet has been
// fully read and no read is pending, dout returns to zero. An idle watchdog
// flushes the FIFO when data sits unread for TIMEOUT cycles.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   we, din, lfd  write request, byte, header marker
//   rd_en         read request
//   dout          registered read data
//   vld_out       FIFO non-empty
//   full, empty   occupancy flags
//   soft_rst      one-cycle pulse after an idle-timeout flush
module router_out_fifo
    import router_pkg::*;
#(
    parameter int unsigned DATA_W  = FIFO_DATA_W,   // must be >= 8 (header length in [7:2])
    parameter int unsigned DEPTH   = FIFO_DEPTH,
    parameter int unsigned TIMEOUT = FIFO_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic              lfd,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              vld_out,
    output logic              full,
    output logic              empty,
    output logic              soft_rst
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    typedef logic [DATA_W:0] entry_t;

    entry_t             mem_q [DEPTH];
    logic [AddrW:0]     wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]     rd_ptr_q, rd_ptr_d;
    byte_cnt_t          cnt_q, cnt_d;
    logic [DATA_W-1:0]  dout_q, dout_d;

    logic   do_wr;
    logic   do_rd;
    logic   flush;
    entry_t rd_word;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                     (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
    assign vld_out = ~empty;

    // A write landing on the timeout edge is lost with the flush.
    assign do_wr   = we & ~full & ~flush;
    assign do_rd   = rd_en & ~empty;
    assign rd_word = mem_q[rd_ptr_q[AddrW-1:0]];

    router_fifo_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .vld_out_i  (vld_out),
        .rd_en_i    (rd_en),
        .flush_o    (flush),
        .soft_rst_o (soft_rst)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            dout_d   = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + (AddrW + 1)'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + (AddrW + 1)'(1);
                dout_d   = rd_word[DATA_W-1:0];
                if (rd_word[DATA_W]) begin
                    cnt_d = hdr_byte_cnt(rd_word[7:2]);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - byte_cnt_t'(1);
                end
            end else if (cnt_q == '0) begin
                // Packet fully delivered: idle the data bus.
                dout_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= {lfd, din};
        end
    end

    assign dout = dout_q;

endmodule

// File: doc/router_out_fifo.md
ROUTER_OUT_FIFO -- requirements
Module: router_out_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of one packet byte.
REQ-002 Parameter DEPTH, default 16, number of storage entries (power of two).
REQ-003 Parameter TIMEOUT, default 30, idle cycles before self-flush.
REQ-004 clk  input  1  single clock; all state sampled on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 we  input  1  write request from router core.
REQ-007 din  input  DATA_W  byte to store.
REQ-008 lfd  input  1  marks din as packet header byte.
REQ-009 rd_en  input  1  read request from destination side.
REQ-010 dout  output  DATA_W  registered read data.
REQ-011 vld_out  output  1  FIFO non-empty.
REQ-012 full  output  1  DEPTH entries occupied.
REQ-013 empty  output  1  zero entries occupied.
REQ-014 soft_rst  output  1  one-cycle pulse when idle timeout fires.

Function
REQ-015 Storage SHALL hold DEPTH entries of DATA_W+1 bits; bit DATA_W stores lfd.
REQ-016 Write SHALL occur on posedge when we=1 and full=0; otherwise din is dropped, no state change.
REQ-017 Read SHALL occur on posedge when rd_en=1 and empty=0; dout updates at that edge (1-cycle latency from sampled rd_en).
REQ-018 With no read, dout SHALL hold its last value, except REQ-022.
REQ-019 Read and write pointers SHALL be log2(DEPTH)+1 bits; full = addresses equal and MSBs differ; empty = pointers equal; wrap is natural modulo rollover.
REQ-020 Simultaneous we and rd_en: when neither full nor empty, both occur, occupancy unchanged; when full, read occurs, write dropped; when empty, write occurs, read ignored.
REQ-021 On reading an entry with header flag set, an internal 6-bit byte counter SHALL load dout[7:2]+1 (payload length plus parity); each subsequent read decrements it by 1, saturating at 0.
REQ-022 When the byte counter is 0 and no read occurs, dout SHALL be driven to 0 on the next edge.
REQ-023 vld_out SHALL equal ~empty combinationally.
REQ-024 Idle counter SHALL increment each cycle with vld_out=1 and rd_en=0, clear on any cycle with rd_en=1 or vld_out=0.
REQ-025 When idle counter reaches TIMEOUT-1 and increments, soft_rst SHALL pulse high for exactly one cycle, and on that same edge pointers, byte counter, idle counter and dout SHALL clear to 0 (FIFO flushed, empty=1).
REQ-026 A write coincident with the timeout edge SHALL be dropped.

Reset
REQ-027 rst=1 SHALL immediately clear pointers, byte counter, idle counter, dout=0, soft_rst=0, empty=1, full=0, vld_out=0.
REQ-028 Storage array contents need not be reset; reset mid-packet SHALL discard the packet with no residual header state.

Structure
REQ-029 DATA_W, DEPTH, TIMEOUT defaults belong in shared package router_pkg alongside existing router constants.
REQ-030 Idle watchdog (REQ-024..026) SHALL be sub-module router_fifo_timer, inputs vld_out/rd_en, output soft_rst pulse.

Verification
REQ-031 Header 8'h0C (lfd=1) plus 3 payload and 1 parity byte written, then rd_en held 5 cycles -> dout sequence 0C, payload, parity, one cycle per read; dout=0 cycle after last.
REQ-032 16 writes with rd_en=0 -> full=1 after 16th; 17th write dropped; 16 reads return original order; empty=1 after last.
REQ-033 Full FIFO, we=1 and rd_en=1 same cycle -> one read, write dropped, full deasserts.
REQ-034 One byte written, rd_en held 0 -> soft_rst pulses exactly 30 cycles after vld_out rises; empty=1 next cycle.
REQ-035 rst asserted between edges mid-packet -> outputs zero without clock edge; fresh packet afterward reads correctly.
REQ-036 40 write/read pairs at alternating rates -> pointer wrap with no data loss or reordering vs scoreboard.
